// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls, ID-stage branch flushes,
// data-memory wait-state freezing with a watchdog, plus saturating debug counters.
module hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_Rt,
   input  logic             Branch_Taken,
   input  logic             MEM_Access,
   input  logic             DMem_Ack,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Clear,
   output logic             ID_EX_Write,
   output logic             ID_EX_Clear,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Clear,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count,
   output logic             Mem_Fault
);

   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

   state_t           state;
   logic [WD_W-1:0]  watchdog;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic             mem_fault;

   logic mem_freeze;
   logic load_use;
   logic flush;
   logic stall;

   // Strobes act in the same cycle; while reset is held they show the RUN idle values.
   always_comb begin
      mem_freeze = (state == MEM_WAIT && !DMem_Ack) ||
                   (state == RUN && MEM_Access && !DMem_Ack);
      load_use   = !mem_freeze && state != FAULT && EX_MemRead && EX_Rt != 5'd0 &&
                   (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt));
      flush      = state != FAULT && Branch_Taken && !load_use && !mem_freeze;
      stall      = mem_freeze || load_use;

      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Clear  = 1'b0;
      ID_EX_Write  = 1'b1;
      ID_EX_Clear  = 1'b0;
      EX_MEM_Write = 1'b1;
      MEM_WB_Clear = 1'b0;

      if (!reset_n) begin
         PC_Write = 1'b1;
      end else if (state == FAULT) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         ID_EX_Clear  = 1'b1;
         MEM_WB_Clear = 1'b1;
      end else if (mem_freeze) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Clear = 1'b1;
      end else if (load_use) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Clear = 1'b1;
      end else if (flush) begin
         PC_Write    = 1'b1;
         IF_ID_Clear = 1'b1;
      end
   end

   // Watchdog counts completed MEM_WAIT cycles; the TIMEOUT-th unacknowledged one faults.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RUN;
         watchdog    <= '0;
         stall_count <= '0;
         flush_count <= '0;
         mem_fault   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (MEM_Access && !DMem_Ack) begin
                  state    <= MEM_WAIT;
                  watchdog <= '0;
               end
            end
            MEM_WAIT: begin
               if (DMem_Ack) begin
                  state <= RUN;
               end else if (watchdog == WD_LAST) begin
                  state     <= FAULT;
                  mem_fault <= 1'b1;
               end else begin
                  watchdog <= watchdog + WD_W'(1);
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state <= RUN;
            end
         endcase

         if (stall && stall_count != '1) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (flush && flush_count != '1) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

   assign Stall_Count = stall_count;
   assign Flush_Count = flush_count;
   assign Mem_Fault   = mem_fault;

endmodule
